// File: rtl/lane_sched_pkg.sv
// Shared types, widths and the lane-period helper for the lane scheduler.
// Optional feature macro used by the top: LANE_ALT_DIR_EN.
package lane_sched_pkg;

    localparam int LEVEL_W = 3;
    localparam int LIVES_W = 2;
    localparam int CNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_e;

    // Frames per move for a lane; clamps at 1 instead of wrapping when level+lane reaches base.
    function automatic logic [CNT_W-1:0] lane_period(
        input logic [3:0]         base,
        input logic [LEVEL_W-1:0] level,
        input logic [2:0]         lane
    );
        logic [CNT_W-1:0] sum;
        sum = CNT_W'(level) + CNT_W'(lane);
        if (sum >= CNT_W'(base)) begin
            return CNT_W'(1);
        end
        return CNT_W'(base) - sum;
    endfunction

endpackage

// File: rtl/lane_divider.sv
// Per-lane frame divider: counts enabled frame strobes and emits a registered
// one-cycle move strobe every period_i frames; clr_i restarts the count.
module lane_divider
    import lane_sched_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             ani_stb_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             stb_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stb_q, stb_d;

    // NOTE: next-state is computed with blocking assignments in always_comb and every
    // variable gets a default first, so no latch can be inferred; registers use <= only.
    always_comb begin
        cnt_d = cnt_q;
        stb_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && ani_stb_i) begin
            if (cnt_q == period_i - CNT_W'(1)) begin
                cnt_d = '0;
                stb_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            stb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            stb_q <= stb_d;
        end
    end

    assign stb_o = stb_q;

endmodule

// File: rtl/lane_scheduler.sv
// Game-state FSM, lives/level tracking and per-lane move strobes for the obstacle rows.
// Define LANE_ALT_DIR_EN to add o_lane_dir (alternating lane directions, flipped per level-up).
module lane_scheduler
    import lane_sched_pkg::*;
#(
    parameter int N_LANES    = 4,
    parameter int BASE_DIV   = 8,
    parameter int MAX_LEVEL  = 7,
    parameter int LIVES_INIT = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ani_stb,
    input  logic               i_start,
    input  logic               i_pause,
    input  logic               i_hit,
    input  logic               i_goal,
    output logic [N_LANES-1:0] o_lane_stb,
`ifdef LANE_ALT_DIR_EN
    output logic [N_LANES-1:0] o_lane_dir,
`endif
    output logic               o_animate,
    output logic               o_lane_rst,
    output logic [1:0]         o_state,
    output logic [LEVEL_W-1:0] o_level,
    output logic [LIVES_W-1:0] o_lives
);

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(MAX_LEVEL);
    localparam logic [LIVES_W-1:0] LIVES_RST = LIVES_W'(LIVES_INIT);

    state_e             state_q;
    logic [LEVEL_W-1:0] level_q;
    logic [LIVES_W-1:0] lives_q;
    logic               lane_rst_q;

    logic in_run, start_evt, hit_evt, goal_evt, cnt_clr, cnt_en;

    // Any hit clears the dividers, including the last one, so no strobe leaks into OVER.
    always_comb begin
        in_run    = (state_q == RUN);
        start_evt = i_start && (state_q == IDLE || state_q == OVER);
        hit_evt   = in_run && i_hit;
        goal_evt  = in_run && i_goal && !i_hit;
        cnt_clr   = start_evt || hit_evt || goal_evt;
        cnt_en    = in_run && !i_pause;
    end

    // Within RUN the priority is hit, then goal, then pause; a pause held alongside
    // a hit or goal takes effect on the following cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            level_q    <= '0;
            lives_q    <= LIVES_RST;
            lane_rst_q <= 1'b1;
        end else begin
            lane_rst_q <= 1'b0;
            case (state_q)
                IDLE, OVER: begin
                    if (i_start) begin
                        state_q    <= RUN;
                        lives_q    <= LIVES_RST;
                        level_q    <= '0;
                        lane_rst_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (i_hit) begin
                        if (lives_q == LIVES_W'(1)) begin
                            lives_q <= '0;
                            state_q <= OVER;
                        end else begin
                            lives_q    <= lives_q - LIVES_W'(1);
                            lane_rst_q <= 1'b1;
                        end
                    end else if (i_goal) begin
                        if (level_q != LEVEL_MAX) begin
                            level_q <= level_q + LEVEL_W'(1);
                        end
                        lane_rst_q <= 1'b1;
                    end else if (i_pause) begin
                        state_q <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (!i_pause) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        lane_divider u_div (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .en_i      (cnt_en),
            .clr_i     (cnt_clr),
            .ani_stb_i (i_ani_stb),
            .period_i  (lane_period(4'(BASE_DIV), level_q, 3'(k))),
            .stb_o     (o_lane_stb[k])
        );
    end

`ifdef LANE_ALT_DIR_EN
    localparam logic [7:0]         DIR_ALL  = 8'h55;
    localparam logic [N_LANES-1:0] DIR_INIT = DIR_ALL[N_LANES-1:0];

    logic [N_LANES-1:0] dir_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || start_evt) begin
            dir_q <= DIR_INIT;
        end else if (goal_evt && level_q != LEVEL_MAX) begin
            dir_q <= ~dir_q;
        end
    end

    assign o_lane_dir = dir_q;
`endif

    assign o_animate  = in_run;
    assign o_lane_rst = lane_rst_q;
    assign o_state    = state_q;
    assign o_level    = level_q;
    assign o_lives    = lives_q;

endmodule

// File: tb/tb_lane_scheduler.sv
// Scoreboard bench for lane_scheduler: a frame-count reference model queues the expected
// outputs per cycle and a negedge monitor compares them, plus directed milestone checks.
module tb_lane_scheduler;

    localparam int N_LANES    = 4;
    localparam int BASE_DIV   = 8;
    localparam int MAX_LEVEL  = 7;
    localparam int LIVES_INIT = 3;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b0;
    logic               i_ani_stb = 1'b0;
    logic               i_start = 1'b0;
    logic               i_pause = 1'b0;
    logic               i_hit = 1'b0;
    logic               i_goal = 1'b0;
    logic [N_LANES-1:0] o_lane_stb;
`ifdef LANE_ALT_DIR_EN
    logic [N_LANES-1:0] o_lane_dir;
`endif
    logic               o_animate;
    logic               o_lane_rst;
    logic [1:0]         o_state;
    logic [2:0]         o_level;
    logic [1:0]         o_lives;

    lane_scheduler #(
        .N_LANES    (N_LANES),
        .BASE_DIV   (BASE_DIV),
        .MAX_LEVEL  (MAX_LEVEL),
        .LIVES_INIT (LIVES_INIT)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_ani_stb  (i_ani_stb),
        .i_start    (i_start),
        .i_pause    (i_pause),
        .i_hit      (i_hit),
        .i_goal     (i_goal),
        .o_lane_stb (o_lane_stb),
`ifdef LANE_ALT_DIR_EN
        .o_lane_dir (o_lane_dir),
`endif
        .o_animate  (o_animate),
        .o_lane_rst (o_lane_rst),
        .o_state    (o_state),
        .o_level    (o_level),
        .o_lives    (o_lives)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [N_LANES-1:0] stb;
        logic               rst;
        logic [1:0]         st;
        logic [2:0]         lvl;
        logic [1:0]         lives;
        logic               anim;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   stb_cnt[N_LANES];
    int   rst_cnt = 0;

    // Reference model: game state as plain integers, lane motion as frames since last restart.
    int m_st = 0;
    int m_lvl = 0;
    int m_lives = LIVES_INIT;
    int m_frames[N_LANES];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int period(input int lvl, input int k);
        int p;
        p = BASE_DIV - lvl - k;
        return (p < 1) ? 1 : p;
    endfunction

    task automatic model_step(input bit rst, input bit ani, input bit start, input bit pause,
                              input bit hit, input bit goal, output exp_t e);
        bit clear;
        clear = 1'b0;
        e.stb = '0;
        e.rst = 1'b0;
        if (rst) begin
            m_st = 0; m_lvl = 0; m_lives = LIVES_INIT; clear = 1'b1; e.rst = 1'b1;
        end else begin
            case (m_st)
                0, 3: if (start) begin
                    m_st = 1; m_lives = LIVES_INIT; m_lvl = 0; e.rst = 1'b1; clear = 1'b1;
                end
                1: begin
                    if (hit) begin
                        clear = 1'b1;
                        if (m_lives == 1) begin
                            m_lives = 0; m_st = 3;
                        end else begin
                            m_lives--; e.rst = 1'b1;
                        end
                    end else if (goal) begin
                        if (m_lvl < MAX_LEVEL) m_lvl++;
                        e.rst = 1'b1; clear = 1'b1;
                    end else begin
                        if (ani && !pause) begin
                            for (int k = 0; k < N_LANES; k++) begin
                                m_frames[k]++;
                                if (m_frames[k] % period(m_lvl, k) == 0) e.stb[k] = 1'b1;
                            end
                        end
                        if (pause) m_st = 2;
                    end
                end
                2: if (!pause) m_st = 1;
                default: ;
            endcase
        end
        if (clear) begin
            for (int k = 0; k < N_LANES; k++) m_frames[k] = 0;
        end
        e.st    = 2'(m_st);
        e.lvl   = 3'(m_lvl);
        e.lives = 2'(m_lives);
        e.anim  = (m_st == 1);
    endtask

    task automatic step(input bit rst, input bit ani, input bit start, input bit pause,
                        input bit hit, input bit goal);
        exp_t e;
        i_rst = rst; i_ani_stb = ani; i_start = start;
        i_pause = pause; i_hit = hit; i_goal = goal;
        model_step(rst, ani, start, pause, hit, goal, e);
        exp_q.push_back(e);
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n, input bit pause);
        for (int i = 0; i < n; i++) step(0, 0, 0, pause, 0, 0);
    endtask

    task automatic frames(input int n, input bit pause);
        for (int i = 0; i < n; i++) begin
            step(0, 1, 0, pause, 0, 0);
            idle(2, pause);
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < N_LANES; k++) stb_cnt[k] = 0;
        rst_cnt = 0;
    endtask

    always @(negedge i_clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("lane_stb", int'(o_lane_stb), int'(e.stb));
            check("lane_rst", int'(o_lane_rst), int'(e.rst));
            check("state",    int'(o_state),    int'(e.st));
            check("level",    int'(o_level),    int'(e.lvl));
            check("lives",    int'(o_lives),    int'(e.lives));
            check("animate",  int'(o_animate),  int'(e.anim));
            for (int k = 0; k < N_LANES; k++) if (o_lane_stb[k]) stb_cnt[k]++;
            if (o_lane_rst) rst_cnt++;
        end
    end

    initial begin
        int exp_cnt[N_LANES];
        bit pause_lvl;
        exp_cnt = '{5, 5, 6, 8};
        for (int k = 0; k < N_LANES; k++) m_frames[k] = 0;

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(2, 0);
        check("reset_state", int'(o_state), 0);
        check("reset_lives", int'(o_lives), LIVES_INIT);

        // 40 frames at level 0
        clear_counts();
        step(0, 0, 1, 0, 0, 0);
        frames(40, 0);
        for (int k = 0; k < N_LANES; k++) check($sformatf("strobes40_lane%0d", k), stb_cnt[k], exp_cnt[k]);

        // Pause with lane 0 five frames into its period
        frames(5, 0);
        clear_counts();
        frames(20, 1);
        for (int k = 0; k < N_LANES; k++) check($sformatf("paused_lane%0d", k), stb_cnt[k], 0);
        idle(2, 0);
        frames(2, 0);
        check("resume_lane0_early", stb_cnt[0], 0);
        frames(1, 0);
        check("resume_lane0_third", stb_cnt[0], 1);

        // Level saturation
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0, 1);
            idle(1, 0);
        end
        check("level_sat", int'(o_level), MAX_LEVEL);
        check("goal_rst_pulses", rst_cnt, 10);
        clear_counts();
        frames(4, 0);
        for (int k = 0; k < N_LANES; k++) check($sformatf("fast_lane%0d", k), stb_cnt[k], 4);

        // Three hits to game over
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1, 0);
            check($sformatf("lives_after_hit%0d", i + 1), int'(o_lives), 2 - i);
            idle(1, 0);
        end
        check("over_state", int'(o_state), 3);
        clear_counts();
        frames(4, 0);
        check("over_no_strobe", stb_cnt[0] + stb_cnt[1] + stb_cnt[2] + stb_cnt[3], 0);
        step(0, 0, 1, 0, 0, 0);
        check("restart_state", int'(o_state), 1);
        check("restart_lives", int'(o_lives), LIVES_INIT);
        check("restart_level", int'(o_level), 0);

        // Simultaneous hit and goal, then reset while paused
        step(0, 0, 0, 0, 0, 1);
        idle(1, 0);
        step(0, 0, 0, 0, 1, 1);
        check("hitgoal_lives", int'(o_lives), 2);
        check("hitgoal_level", int'(o_level), 1);
        idle(2, 1);
        check("paused_state", int'(o_state), 2);
        step(1, 0, 0, 1, 0, 0);
        idle(1, 0);
        check("rst_pause_state", int'(o_state), 0);
        check("rst_pause_level", int'(o_level), 0);
        check("rst_pause_lives", int'(o_lives), LIVES_INIT);

        // Random traffic
        pause_lvl = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) pause_lvl = ~pause_lvl;
            step($urandom_range(0, 599) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 24) == 0, pause_lvl,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0);
        end

        idle(1, 0);
        @(negedge i_clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lane_scheduler.md
Name: lane_scheduler

Overview:
Sequences the obstacle rows of the game screen.
- Divides the frame-rate animation strobe into a per-lane move strobe, with a different speed per lane.
- Runs the game-state FSM (idle/run/pause/over), tracking lives and level.
- Issues a one-cycle row-reset pulse so every row returns to its start position on a new game, a death or a level-up.
- Sits between the VGA timing strobe and the bank of row instances; its outputs drive each row's i_ani_stb, i_animate and i_rst.

Parameters:
N_LANES, 4, number of obstacle rows scheduled (1..8)
BASE_DIV, 8, frames per move for lane 0 at level 0 (2..15)
MAX_LEVEL, 7, saturating level ceiling (<=7)
LIVES_INIT, 3, lives at game start (1..3)

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
i_ani_stb  in  1  one-cycle frame strobe (one per frame)
i_start  in  1  start-game pulse
i_pause  in  1  level; high holds the game
i_hit  in  1  collision pulse from the frog/obstacle checker
i_goal  in  1  frog-reached-top pulse
o_lane_stb  out  N_LANES  per-lane move strobe, one cycle wide
o_animate  out  1  high only in RUN
o_lane_rst  out  1  one-cycle row-reset pulse
o_state  out  2  IDLE=0, RUN=1, PAUSE=2, OVER=3
o_level  out  3  current level
o_lives  out  2  remaining lives

Behaviour:
- Reset values: state IDLE, level 0, lives LIVES_INIT, all divider counters 0, o_lane_stb 0, o_lane_rst 1 for the cycle after reset, then 0.
- Lane period: P_k = max(1, BASE_DIV - level - k), computed in 5-bit unsigned with clamping, never wrapping.
- Divider k:
  - Counts i_ani_stb only while in RUN.
  - On an i_ani_stb with cnt_k == P_k-1: cnt_k <= 0 and o_lane_stb[k] is registered high on the next cycle (latency 1).
  - Otherwise cnt_k increments.
- If P_k shrinks below cnt_k+1 (level-up), the counter is cleared by the accompanying o_lane_rst, so no stale compare occurs.
- FSM transitions:
  - IDLE: i_start -> RUN; lives<=LIVES_INIT, level<=0, o_lane_rst pulse.
  - RUN: i_pause -> PAUSE (counters held, o_animate 0, no strobes).
  - RUN: i_hit -> lives-1. If lives==1 -> OVER (lives 0). Else stay in RUN with an o_lane_rst pulse and counters cleared.
  - RUN: i_goal -> level+1, saturating at MAX_LEVEL; o_lane_rst pulse; counters cleared.
  - PAUSE: ~i_pause -> RUN; counters resume from their held values. i_hit and i_goal are ignored.
  - OVER: all strobes 0; level and lives frozen for display; i_start -> RUN as in IDLE.
- Simultaneous events:
  - i_hit and i_goal in the same cycle: hit wins, goal is dropped.
  - i_pause and i_hit in the same cycle in RUN: hit is processed, pause takes effect next cycle.
  - i_start is ignored in RUN and PAUSE.
- o_lane_rst and o_lane_stb are never high in the same cycle; o_lane_rst has priority.
- i_rst mid-game: returns to IDLE the next cycle regardless of state and event inputs.

Optional Feature:
LANE_ALT_DIR_EN
- Defined:
  - Adds port o_lane_dir (out, N_LANES).
  - Reset/start value: even lanes 1 (right), odd lanes 0 (left).
  - Every level-up inverts all bits, registered with the o_lane_rst pulse.
  - Hits do not change direction.
- Undefined: port absent; rows use their own IX_DIR parameter.

Decomposition:
- Package lane_sched_pkg:
  - state enum (IDLE/RUN/PAUSE/OVER, 2-bit)
  - LEVEL_W=3, LIVES_W=2, CNT_W=5
  - lane-period function with clamping
- Sub-module lane_divider: one divider per lane (counter, period compare, registered strobe, hold/clear inputs), instantiated by generate over N_LANES.
- The FSM, lives and level logic stay in the top module.

Test Plan:
- Reset, i_start, then 40 i_ani_stb (defaults) -> strobe counts: lane0 5 (period 8), lane1 5 (period 7), lane2 6 (period 6), lane3 8 (period 5); each strobe is exactly one cycle wide and lands one cycle after its i_ani_stb.
- 7 i_goal pulses, then 3 more -> o_level saturates at 7. Lane periods become 1,1,1,1, so every i_ani_stb strobes all lanes. o_lane_rst fires on every goal.
- 3 i_hit in RUN -> o_lives 2,1,0; state OVER after the third hit; no o_lane_stb afterwards. A later i_start -> RUN, lives 3, level 0.
- i_pause high for 20 frames mid-count (lane0 cnt=5) -> no strobes while paused. After release, the first lane0 strobe arrives after exactly 3 more frames.
- i_hit and i_goal in the same cycle with lives=3 -> lives 2, level unchanged. i_rst asserted during PAUSE -> IDLE, level 0, lives 3.
- With LANE_ALT_DIR_EN defined: o_lane_dir = 4'b0101 after start, 4'b1010 after one goal, unchanged after a hit.
